// File: rtl/pipeline_hazard_controller_pkg.sv
// cpu_ctrl_pkg: shared FSM encoding and register-file constants for the hazard controller.
// No ports. Exports fsm_e (RUN, MEM_WAIT, ERROR), REG_ADDR_W and ZERO_REG.
package cpu_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } fsm_e;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: bundle between the pipeline datapath and its hazard controller.
// master: pipeline side, drives the ID/EX/MEM hazard fields and dmem_ready, receives the controls.
// slave : controller side, receives the hazard fields, drives enables, flushes, dmem_req, status.
interface pipeline_hazard_controller_if #(
    parameter int STALL_W = 16
);
    import cpu_ctrl_pkg::*;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_write_reg_addr;
    logic                  mem_branch;
    logic                  mem_alu_zero;
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  dmem_ready;
    logic                  dmem_req;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_write;
    logic                  ex_mem_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mem_wb_bubble;
    logic                  branch_taken;
    logic                  bus_error;
    logic [STALL_W-1:0]    stall_count;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_write_reg_addr,
               mem_branch, mem_alu_zero, mem_mem_read, mem_mem_write, dmem_ready,
        input  dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
               branch_taken, bus_error, stall_count
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_write_reg_addr,
               mem_branch, mem_alu_zero, mem_mem_read, mem_mem_write, dmem_ready,
        output dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
               branch_taken, bus_error, stall_count
    );
endinterface

// File: rtl/load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the destination of a load sitting in EX.
// Inputs : id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_mem_read_i, ex_write_reg_addr_i
// Output : lu_haz_o (combinational)
module load_use_detector
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_write_reg_addr_i,
    output logic                  lu_haz_o
);
    // $0 is hardwired to zero, so a load targeting it never produces a dependency
    assign lu_haz_o = ex_mem_read_i & (ex_write_reg_addr_i != ZERO_REG) &
                      ((ex_write_reg_addr_i == id_rs_addr_i) |
                       (id_uses_rt_i & (ex_write_reg_addr_i == id_rt_addr_i)));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing for a 5-stage pipeline with a handshaked data memory.
// clk : rising-edge clock
// rst : asynchronous active-high reset
// bus : slave side of pipeline_hazard_controller_if (hazard fields in; enables, flushes,
//       dmem_req, branch_taken, bus_error and the saturating stall_count out)
module pipeline_hazard_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8,
    parameter int STALL_W = 16
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_controller_if.slave bus
);
    fsm_e               fsm_d, fsm_q;
    logic [CNT_W-1:0]   wait_d, wait_q;
    logic [STALL_W-1:0] stall_d, stall_q;
    logic               mem_acc, lu_haz, err, freeze, br, lu;

    load_use_detector u_lud (
        .id_rs_addr_i        (bus.id_rs_addr),
        .id_rt_addr_i        (bus.id_rt_addr),
        .id_uses_rt_i        (bus.id_uses_rt),
        .ex_mem_read_i       (bus.ex_mem_read),
        .ex_write_reg_addr_i (bus.ex_write_reg_addr),
        .lu_haz_o            (lu_haz)
    );

    assign mem_acc = bus.mem_mem_read | bus.mem_mem_write;
    assign err     = fsm_q == ERROR;
    // The same freeze condition covers RUN and MEM_WAIT; a dropped mem_acc in MEM_WAIT
    // therefore falls through to the branch / load-use rules like a completion.
    assign freeze  = !err & mem_acc & !bus.dmem_ready;
    assign br      = !err & !freeze & bus.mem_branch & bus.mem_alu_zero;
    assign lu      = !err & !freeze & !br & lu_haz;

    assign bus.dmem_req      = !rst & !err & mem_acc;
    assign bus.pc_write      = !rst & !err & !freeze & !lu;
    assign bus.if_id_write   = !rst & !err & !freeze & !lu;
    assign bus.id_ex_write   = !rst & !err & !freeze;
    assign bus.ex_mem_write  = !rst & !err & !freeze;
    assign bus.if_id_flush   = rst | br;
    assign bus.id_ex_flush   = rst | br | lu;
    assign bus.ex_mem_flush  = rst | br;
    assign bus.mem_wb_bubble = rst | err | freeze;
    assign bus.branch_taken  = !rst & br;
    assign bus.bus_error     = !rst & err;
    assign bus.stall_count   = stall_q;

    always_comb begin
        fsm_d  = fsm_q;
        wait_d = wait_q;
        if (fsm_q == RUN && freeze) begin
            fsm_d  = MEM_WAIT;
            wait_d = CNT_W'(1);
        end else if (fsm_q == MEM_WAIT) begin
            if (!freeze) begin
                fsm_d  = RUN;
                wait_d = '0;
            end else if (wait_q == CNT_W'(TIMEOUT)) begin
                fsm_d  = ERROR;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        stall_d = (!bus.pc_write && !err && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench; expected controls and stall count are queued per driven cycle and popped at the falling edge.
module tb_pipeline_hazard_controller;
    import cpu_ctrl_pkg::*;
    localparam int SW = 4;
    localparam int TO = 4;
    // {dmem_req, pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, bubble, br_taken, bus_error}
    localparam logic [10:0] IDLE = 11'b0_1111_000_0_0_0;
    localparam logic [10:0] RSTV = 11'b0_0000_111_1_0_0;
    localparam logic [10:0] LU   = 11'b0_0011_010_0_0_0;
    localparam logic [10:0] BR   = 11'b0_1111_111_0_1_0;
    localparam logic [10:0] FRZ  = 11'b1_0000_000_1_0_0;
    localparam logic [10:0] MOK  = 11'b1_1111_000_0_0_0;
    localparam logic [10:0] MLU  = 11'b1_0011_010_0_0_0;
    localparam logic [10:0] MBR  = 11'b1_1111_111_0_1_0;
    localparam logic [10:0] ERR  = 11'b0_0000_000_1_0_1;

    typedef struct packed {
        logic [4:0]  rs, rt;
        logic        ur, er;
        logic [4:0]  ew;
        logic        b, z, mr, mw, rdy;
        logic [10:0] e;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [SW-1:0]   exp_stall = '0;
    logic [10+SW:0]  sb[$];
    logic [10+SW:0]  exp_v, got_v;

    pipeline_hazard_controller_if #(.STALL_W(SW)) bus ();
    pipeline_hazard_controller #(.TIMEOUT(TO), .CNT_W(8), .STALL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [10+SW:0] obs();
        return {bus.dmem_req, bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_bubble,
                bus.branch_taken, bus.bus_error, bus.stall_count};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                 input logic er, input logic [4:0] ew, input logic b, input logic z,
                                 input logic mr, input logic mw, input logic rdy, input logic [10:0] e);
        return '{rs: rs, rt: rt, ur: ur, er: er, ew: ew, b: b, z: z, mr: mr, mw: mw, rdy: rdy, e: e};
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs_addr        = s.rs;
        bus.id_rt_addr        = s.rt;
        bus.id_uses_rt        = s.ur;
        bus.ex_mem_read       = s.er;
        bus.ex_write_reg_addr = s.ew;
        bus.mem_branch        = s.b;
        bus.mem_alu_zero      = s.z;
        bus.mem_mem_read      = s.mr;
        bus.mem_mem_write     = s.mw;
        bus.dmem_ready        = s.rdy;
    endtask

    // Queue the expectation for this cycle and advance the stall model for the coming edge.
    task automatic push(input logic [10:0] c);
        sb.push_back({c, exp_stall});
        if (!c[9] && !c[0] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        stim_t t[$];
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        #1;
        push(RSTV);
        exp_v = sb.pop_front(); got_v = obs(); checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got_v, exp_v); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = '0;
        t = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL reset_pre step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
        // mid-cycle assertion while waiting on memory with the wait counter at 3
        #2;
        rst = 1'b1;
        exp_stall = '0;
        #1;
        push(RSTV);
        exp_v = sb.pop_front(); got_v = obs(); checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL reset_async got=%h exp=%h", got_v, exp_v); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = '0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        push(IDLE);
        @(negedge clk);
        exp_v = sb.pop_front(); got_v = obs(); checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t t[$];
        do_reset();
        t = '{mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0, LU),
              mk(8, 0, 0, 0, 8, 0, 0, 0, 0, 0, IDLE),
              mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, IDLE),
              mk(3, 9, 0, 1, 9, 0, 0, 0, 0, 0, IDLE),
              mk(3, 9, 1, 1, 9, 0, 0, 0, 0, 0, LU),
              mk(3, 9, 1, 0, 9, 0, 0, 0, 0, 0, IDLE)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL load_use step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        stim_t t[$];
        do_reset();
        t = '{mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, BR),
              mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, IDLE),
              mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, IDLE)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL branch step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t t[$];
        do_reset();
        t = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MOK),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL mem_wait step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        do_reset();
        t = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MOK),
              mk(5, 0, 0, 1, 5, 0, 0, 0, 1, 1, MLU),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MOK)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL back_to_back step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_timeout();
        stim_t t[$];
        do_reset();
        t = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ERR),
              mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ERR),
              mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ERR),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ERR)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL timeout step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
        do_reset();
        push(IDLE);
        @(negedge clk);
        exp_v = sb.pop_front(); got_v = obs(); checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL timeout_recover got=%h exp=%h", got_v, exp_v); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        stim_t t[$];
        do_reset();
        t = '{mk(8, 0, 0, 1, 8, 1, 1, 0, 1, 0, FRZ),
              mk(8, 0, 0, 1, 8, 1, 1, 0, 1, 1, MBR),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE)};
        foreach (t[i]) begin
            apply(t[i]);
            push(t[i].e);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL simultaneous step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            apply(i < 20 ? mk(7, 0, 0, 1, 7, 0, 0, 0, 0, 0, LU) : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
            push(i < 20 ? LU : IDLE);
            @(negedge clk);
            exp_v = sb.pop_front(); got_v = obs(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL saturate step%0d got=%h exp=%h", i, got_v, exp_v); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_simultaneous();
        test_saturate();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
